// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, colour constants and coordinate type
package vga_pkg;

    typedef logic [9:0] coord_t;
    typedef logic [2:0] colour_t;

    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam colour_t BLACK = 3'b000;
    localparam colour_t WHITE = 3'b111;

    // True when lo <= v < lo+len; used for the sync pulse windows.
    function automatic logic in_span(coord_t v, int lo, int len);
        return (v >= coord_t'(lo)) && (v < coord_t'(lo + len));
    endfunction

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - coordinate broadcast, colour return and VGA connector bundle
interface vga_if;
    import vga_pkg::*;

    coord_t  row;
    coord_t  col;
    logic    video_on;
    logic    pix_en;
    logic    frame_tick;
    colour_t rgb_in;
    logic    vga_hsync;
    logic    vga_vsync;
    colour_t vga_rgb;

    modport master (
        input  rgb_in,
        output row, col, video_on, pix_en, frame_tick,
        output vga_hsync, vga_vsync, vga_rgb
    );

    modport slave (
        output rgb_in,
        input  row, col, video_on, pix_en, frame_tick,
        input  vga_hsync, vga_vsync, vga_rgb
    );

endinterface

// File: rtl/vga_pixel_enable.sv
// rtl/vga_pixel_enable.sv - system clock divider producing the one-clock pixel strobe
module vga_pixel_enable #(
    parameter int CLK_DIV = 2
) (
    input  logic clock,
    input  logic reset,
    output logic pix_en
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0] div;

    always_ff @(posedge clock) begin
        if (reset || div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + 4'd1;
        end
    end

    // Gated by reset so CLK_DIV=1 still yields no strobe while reset is held.
    assign pix_en = !reset && (div == DIV_LAST);

endmodule

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - 640x480 VGA timing, coordinate broadcast and registered output stage
// VGA_TEST_PATTERN_EN replaces rgb_in with 64-px colour bars taken from col[8:6].
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic clock,
    input  logic reset,
    vga_if.master bus
);

    localparam coord_t H_LAST = coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam coord_t V_LAST = coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam coord_t H_VIS  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS  = coord_t'(V_VISIBLE);

    coord_t  row;
    coord_t  col;
    logic    pix_en;
    logic    video_on;
    logic    hs;
    logic    vs;
    colour_t pix_colour;

    vga_pixel_enable #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_enable (
        .clock  (clock),
        .reset  (reset),
        .pix_en (pix_en)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (pix_en) begin
            if (col == H_LAST) begin
                col <= '0;
                row <= (row == V_LAST) ? '0 : row + 10'd1;
            end else begin
                col <= col + 10'd1;
            end
        end
    end

    assign video_on = (row < V_VIS) && (col < H_VIS);
    assign hs       = !in_span(col, H_VISIBLE + H_FRONT, H_SYNC);
    assign vs       = !in_span(row, V_VISIBLE + V_FRONT, V_SYNC);

`ifdef VGA_TEST_PATTERN_EN
    assign pix_colour = col[8:6];
`else
    assign pix_colour = bus.rgb_in;
`endif

    // One pixel of delay on colour and both syncs keeps them mutually aligned.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.vga_rgb   <= BLACK;
            bus.vga_hsync <= 1'b1;
            bus.vga_vsync <= 1'b1;
        end else if (pix_en) begin
            bus.vga_rgb   <= video_on ? pix_colour : BLACK;
            bus.vga_hsync <= hs;
            bus.vga_vsync <= vs;
        end
    end

    assign bus.row        = row;
    assign bus.col        = col;
    assign bus.video_on   = video_on;
    assign bus.pix_en     = pix_en;
    assign bus.frame_tick = pix_en && (row == V_LAST) && (col == H_LAST);

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - bench for vga_timing: default-size table checks plus a reduced-size model run
module tb_vga_timing;

    localparam int BD  = 3;
    localparam int BHV = 16, BHF = 2, BHS = 4, BHB = 3;
    localparam int BVV = 8,  BVF = 1, BVS = 2, BVB = 2;
    localparam int BHT = BHV + BHF + BHS + BHB;
    localparam int BVT = BVV + BVF + BVS + BVB;

    logic clock = 1'b0;
    logic reset_a, reset_b;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mk = 0;
    logic [2:0] m_rgb = 3'd0;
    bit   b_en = 1'b0;

    vga_if bus_a();
    vga_if bus_b();

    vga_timing dut_a (.clock(clock), .reset(reset_a), .bus(bus_a.master));

    vga_timing #(
        .CLK_DIV(BD), .H_VISIBLE(BHV), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
        .V_VISIBLE(BVV), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB)
    ) dut_b (.clock(clock), .reset(reset_b), .bus(bus_b.master));

    always #5 clock = ~clock;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void expired(string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endfunction

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    // Reference: after k unreset edges, k/BD pixels have been completed.
    function automatic logic [2:0] model_colour(int p, logic [2:0] src);
        int r, c;
        r = (p / BHT) % BVT;
        c = p % BHT;
        if (!(r < BVV && c < BHV)) return 3'd0;
`ifdef VGA_TEST_PATTERN_EN
        return 3'((c >> 6) & 7);
`else
        return src;
`endif
    endfunction

    function automatic logic [27:0] model_b(int k, logic rst, logic [2:0] held);
        int p, r, c, pr, pc;
        logic pe, ft, hs, vs, vo;
        p  = k / BD;
        r  = (p / BHT) % BVT;
        c  = p % BHT;
        pe = !rst && (k % BD == BD - 1);
        ft = pe && r == BVT - 1 && c == BHT - 1;
        vo = (r < BVV) && (c < BHV);
        if (p == 0) begin
            hs = 1'b1;
            vs = 1'b1;
        end else begin
            pr = ((p - 1) / BHT) % BVT;
            pc = (p - 1) % BHT;
            hs = !(pc >= BHV + BHF && pc < BHV + BHF + BHS);
            vs = !(pr >= BVV + BVF && pr < BVV + BVF + BVS);
        end
        return {10'(r), 10'(c), vo, pe, ft, hs, vs, held};
    endfunction

    always @(posedge clock) begin
        if (reset_b) begin
            mk    <= 0;
            m_rgb <= 3'd0;
        end else begin
            if (mk % BD == BD - 1) m_rgb <= model_colour(mk / BD, bus_b.rgb_in);
            mk <= mk + 1;
        end
    end

    always @(negedge clock) begin
        if (b_en) begin
            check("b_cycle",
                  32'({bus_b.row, bus_b.col, bus_b.video_on, bus_b.pix_en, bus_b.frame_tick,
                       bus_b.vga_hsync, bus_b.vga_vsync, bus_b.vga_rgb}),
                  32'(model_b(mk, reset_b, m_rgb)));
        end
    end

    typedef struct {
        int         row;
        int         col;
        logic [2:0] rgb;
        logic [2:0] exp_rgb;
        logic [2:0] exp_pat;
        logic       exp_hs;
    } vec_t;

    vec_t vecs[13];

    task automatic check_reset_a(string tag);
        check({tag, "_row"},   32'(bus_a.row), 32'd0);
        check({tag, "_col"},   32'(bus_a.col), 32'd0);
        check({tag, "_hsync"}, 32'(bus_a.vga_hsync), 32'd1);
        check({tag, "_vsync"}, 32'(bus_a.vga_vsync), 32'd1);
        check({tag, "_rgb"},   32'(bus_a.vga_rgb), 32'd0);
        check({tag, "_tick"},  32'(bus_a.frame_tick), 32'd0);
        check({tag, "_pixen"}, 32'(bus_a.pix_en), 32'd0);
    endtask

    task automatic wait_pos(int r, int c, output bit ok);
        int n = 0;
        ok = 1'b1;
        while (!(bus_a.pix_en && bus_a.row == 10'(r) && bus_a.col == 10'(c))) begin
            step();
            n++;
            if (n > 20000) begin ok = 1'b0; return; end
        end
    endtask

    task automatic phase_a();
        bit ok;
        int n, m;
        vecs[0]  = '{5, 10,  3'd7, 3'd7, 3'd0, 1'b1};
        vecs[1]  = '{5, 11,  3'd2, 3'd2, 3'd0, 1'b1};
        vecs[2]  = '{5, 64,  3'd5, 3'd5, 3'd1, 1'b1};
        vecs[3]  = '{5, 448, 3'd3, 3'd3, 3'd7, 1'b1};
        vecs[4]  = '{5, 512, 3'd6, 3'd6, 3'd0, 1'b1};
        vecs[5]  = '{5, 639, 3'd7, 3'd7, 3'd1, 1'b1};
        vecs[6]  = '{5, 640, 3'd7, 3'd0, 3'd0, 1'b1};
        vecs[7]  = '{5, 655, 3'd7, 3'd0, 3'd0, 1'b1};
        vecs[8]  = '{5, 656, 3'd7, 3'd0, 3'd0, 1'b0};
        vecs[9]  = '{5, 700, 3'd7, 3'd0, 3'd0, 1'b0};
        vecs[10] = '{5, 751, 3'd7, 3'd0, 3'd0, 1'b0};
        vecs[11] = '{5, 752, 3'd7, 3'd0, 3'd0, 1'b1};
        vecs[12] = '{6, 0,   3'd7, 3'd7, 3'd0, 1'b1};

        reset_a = 1'b1;
        bus_a.rgb_in = 3'd0;
        step();
        check_reset_a("a_init");
        step();
        step();
        reset_a = 1'b0;

        foreach (vecs[i]) begin
            wait_pos(vecs[i].row, vecs[i].col, ok);
            if (!ok) begin expired("a_vec_pos"); return; end
            bus_a.rgb_in = vecs[i].rgb;
            n = 0;
            do begin step(); n++; end while (!bus_a.pix_en && n < 100);
            check("a_vec_col", 32'(bus_a.col), 32'((vecs[i].col + 1) % 800));
`ifdef VGA_TEST_PATTERN_EN
            check("a_vec_rgb", 32'(bus_a.vga_rgb), 32'(vecs[i].exp_pat));
`else
            check("a_vec_rgb", 32'(bus_a.vga_rgb), 32'(vecs[i].exp_rgb));
`endif
            check("a_vec_hsync", 32'(bus_a.vga_hsync), 32'(vecs[i].exp_hs));
        end
        check("a_vsync_idle", 32'(bus_a.vga_vsync), 32'd1);

        // Mid-frame reset held for three clocks, then restart from (0,0).
        reset_a = 1'b1;
        step();
        check_reset_a("a_mid");
        step();
        step();
        reset_a = 1'b0;
        check("a_rel0_pixen", 32'(bus_a.pix_en), 32'd0);
        step();
        check("a_rel1_pixen", 32'(bus_a.pix_en), 32'd1);
        check("a_rel1_col", 32'(bus_a.col), 32'd0);
        step();
        check("a_rel2_pixen", 32'(bus_a.pix_en), 32'd0);
        check("a_rel2_col", 32'(bus_a.col), 32'd1);

        n = 0;
        while (bus_a.vga_hsync !== 1'b0 && n < 4000) begin step(); n++; end
        if (n >= 4000) begin expired("a_hs_fall"); return; end
        check("a_hs_fall_col", 32'(bus_a.col), 32'd657);
        n = 0;
        while (bus_a.vga_hsync === 1'b0 && n < 4000) begin step(); n++; end
        check("a_hs_low_clocks", 32'(n), 32'd192);
        check("a_hs_rise_col", 32'(bus_a.col), 32'd753);
        m = 0;
        while (bus_a.vga_hsync !== 1'b0 && m < 4000) begin step(); m++; end
        check("a_hs_period", 32'(n + m), 32'd1600);
    endtask

    task automatic phase_b();
        int n, rst_left;
        reset_b = 1'b1;
        bus_b.rgb_in = 3'd0;
        step();
        b_en = 1'b1;
        step();
        step();
        reset_b = 1'b0;

        n = 0;
        while (!bus_b.frame_tick && n < 3000) begin bus_b.rgb_in = 3'($urandom_range(0, 7)); step(); n++; end
        if (n >= 3000) begin expired("b_tick_first"); return; end
        step();
        check("b_tick_width", 32'(bus_b.frame_tick), 32'd0);
        n = 1;
        while (!bus_b.frame_tick && n < 3000) begin step(); n++; end
        check("b_tick_spacing", 32'(n), 32'(BHT * BVT * BD));

        n = 0;
        while (bus_b.vga_vsync !== 1'b0 && n < 3000) begin step(); n++; end
        if (n >= 3000) begin expired("b_vs_fall"); return; end
        n = 0;
        while (bus_b.vga_vsync === 1'b0 && n < 3000) begin step(); n++; end
        check("b_vs_low_clocks", 32'(n), 32'(BVS * BHT * BD));

        rst_left = 0;
        for (int i = 0; i < 8000; i++) begin
            bus_b.rgb_in = 3'($urandom_range(0, 7));
            if (rst_left > 0) rst_left--;
            else if ($urandom_range(0, 599) == 0) rst_left = $urandom_range(1, 4);
            reset_b = (rst_left > 0);
            step();
        end
        reset_b = 1'b0;
        step();
    endtask

    initial begin
        fork
            phase_a();
            phase_b();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
